// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset control sequencer.
package mc_ctrl_pkg;

  localparam int unsigned OPCODE_W    = 6;
  localparam int unsigned WAIT_W      = 4;
  localparam int unsigned MEM_TIMEOUT = 15;
  localparam int unsigned LINK_GTZ    = 13;
  localparam int unsigned LINK_RA     = 31;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_WB_R,
    ST_ADDR,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_WB_MEM,
    ST_BRANCH,
    ST_LINK,
    ST_JMEM,
    ST_JREG,
    ST_RETIRE,
    ST_ILLEGAL,
    ST_HALT
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_LW     = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW     = 6'h2B;
  localparam logic [OPCODE_W-1:0] OP_BEQ    = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BRNV   = 6'h14;
  localparam logic [OPCODE_W-1:0] OP_BGTZAL = 6'h17;
  localparam logic [OPCODE_W-1:0] OP_BALV   = 6'h16;
  localparam logic [OPCODE_W-1:0] OP_JMNOR  = 6'h18;
  localparam logic [OPCODE_W-1:0] OP_JRSAL  = 6'h19;

  localparam logic [1:0] PC_SRC_ALU  = 2'd0;
  localparam logic [1:0] PC_SRC_BTGT = 2'd1;
  localparam logic [1:0] PC_SRC_RS   = 2'd2;
  localparam logic [1:0] PC_SRC_MDR  = 2'd3;

  localparam logic [1:0] ALUB_RT      = 2'd0;
  localparam logic [1:0] ALUB_FOUR    = 2'd1;
  localparam logic [1:0] ALUB_IMM     = 2'd2;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_GTZ = 2'd2;
  localparam logic [1:0] DST_RA  = 2'd3;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  // One cycle's worth of datapath control.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
  } ctrl_t;

endpackage

// File: rtl/mc_branch_eval.sv
// Branch taken decision for beq/brnv/bgtzal/balv from the ALU flags.
module mc_branch_eval
  import mc_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                ovf,
  input  logic                gtz,
  output logic                taken_c
);

  always_comb begin
    taken_c = 1'b0;
    case (opcode)
      OP_BEQ:    taken_c = zero;
      OP_BGTZAL: taken_c = gtz;
      OP_BALV:   taken_c = ovf;
      OP_BRNV:   taken_c = !ovf;
      default:   taken_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer with memory req/ack handshake, timeout fault and retire counter.
// Build option: MC_ILLEGAL_TRAP_EN makes an illegal opcode fault and halt instead of retiring as a NOP.
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                ovf,
  input  logic                gtz,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          wb_sel,
  output logic [31:0]         retired,
  output logic                fault
);

  state_t            state, state_nxt;
  ctrl_t             ctl;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              fault_set;
  logic              retire_inc;
  logic              taken;

  mc_branch_eval u_branch_eval (
    .opcode  (opcode),
    .zero    (zero),
    .ovf     (ovf),
    .gtz     (gtz),
    .taken_c (taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_FETCH;
      wait_cnt <= '0;
      retired  <= '0;
      fault    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (retire_inc) retired <= retired + 32'd1;
      if (fault_set)  fault   <= 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    ctl          = '0;
    wait_cnt_nxt = '0;
    fault_set    = 1'b0;
    retire_inc   = 1'b0;
    case (state)
      ST_FETCH: begin
        ctl.mem_req   = 1'b1;
        ctl.alu_src_b = ALUB_FOUR;
        ctl.alu_op    = ALU_ADD;
        if (mem_ack) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          ctl.pc_src   = PC_SRC_ALU;
          state_nxt    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ctl.alu_src_b = ALUB_IMM_SH2;
        ctl.alu_op    = ALU_ADD;
        case (opcode)
          OP_RTYPE:                           state_nxt = ST_EXEC_R;
          OP_LW, OP_SW, OP_JMNOR:             state_nxt = ST_ADDR;
          OP_BEQ, OP_BRNV, OP_BGTZAL, OP_BALV: state_nxt = ST_BRANCH;
          OP_JRSAL:                           state_nxt = ST_JREG;
          default:                            state_nxt = ST_ILLEGAL;
        endcase
      end
      ST_EXEC_R: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = ALUB_RT;
        ctl.alu_op    = ALU_FUNCT;
        state_nxt     = ST_WB_R;
      end
      ST_WB_R: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = DST_RD;
        ctl.wb_sel    = WB_ALU;
        state_nxt     = ST_RETIRE;
      end
      ST_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = ALUB_IMM;
        ctl.alu_op    = ALU_ADD;
        state_nxt     = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        ctl.mem_req = 1'b1;
        ctl.iord    = 1'b1;
        if (mem_ack) state_nxt = (opcode == OP_JMNOR) ? ST_JMEM : ST_WB_MEM;
      end
      ST_MEM_WR: begin
        ctl.mem_req = 1'b1;
        ctl.mem_we  = 1'b1;
        ctl.iord    = 1'b1;
        if (mem_ack) state_nxt = ST_RETIRE;
      end
      ST_WB_MEM: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = DST_RT;
        ctl.wb_sel    = WB_MDR;
        state_nxt     = ST_RETIRE;
      end
      ST_BRANCH: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = ALUB_RT;
        ctl.alu_op    = ALU_SUB;
        state_nxt     = ST_RETIRE;
        if (taken) begin
          ctl.pc_write = 1'b1;
          ctl.pc_src   = (opcode == OP_BRNV) ? PC_SRC_RS : PC_SRC_BTGT;
          if (opcode == OP_BGTZAL || opcode == OP_BALV) state_nxt = ST_LINK;
        end
      end
      ST_LINK: begin
        ctl.reg_write = 1'b1;
        ctl.wb_sel    = WB_PC;
        ctl.reg_dst   = (opcode == OP_BGTZAL) ? DST_GTZ : DST_RA;
        state_nxt     = ST_RETIRE;
      end
      ST_JMEM: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_src    = PC_SRC_MDR;
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = DST_RA;
        ctl.wb_sel    = WB_PC;
        state_nxt     = ST_RETIRE;
      end
      ST_JREG: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_src    = PC_SRC_RS;
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = DST_RD;
        ctl.wb_sel    = WB_PC;
        state_nxt     = ST_RETIRE;
      end
      ST_RETIRE: begin
        retire_inc = 1'b1;
        state_nxt  = ST_FETCH;
      end
      ST_ILLEGAL: begin
`ifdef MC_ILLEGAL_TRAP_EN
        fault_set = 1'b1;
        state_nxt = ST_HALT;
`else
        state_nxt = ST_RETIRE;
`endif
      end
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_FETCH;
    endcase

    // Memory wait: the cycle that would bring the count to MEM_TIMEOUT faults unless acked.
    if (ctl.mem_req && !mem_ack) begin
      if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
        fault_set = 1'b1;
        state_nxt = ST_HALT;
      end else begin
        wait_cnt_nxt = wait_cnt + WAIT_W'(1);
      end
    end
  end

  // Requests are gated by reset so a transfer is abandoned the moment reset asserts.
  assign mem_req   = ctl.mem_req & rst_n;
  assign mem_we    = ctl.mem_we & rst_n;
  assign iord      = ctl.iord;
  assign ir_write  = ctl.ir_write;
  assign pc_write  = ctl.pc_write;
  assign pc_src    = ctl.pc_src;
  assign alu_src_a = ctl.alu_src_a;
  assign alu_src_b = ctl.alu_src_b;
  assign alu_op    = ctl.alu_op;
  assign reg_write = ctl.reg_write;
  assign reg_dst   = ctl.reg_dst;
  assign wb_sel    = ctl.wb_sel;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench: per-instruction expected control sequences compared every cycle.
module tb_mc_control_fsm;
  import mc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        zero, ovf, gtz, mem_ack;
  logic        mem_req, mem_we, iord, ir_write, pc_write, alu_src_a, reg_write, fault;
  logic [1:0]  pc_src, alu_src_b, alu_op, reg_dst, wb_sel;
  logic [31:0] retired;

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic        iord;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic [1:0]  wb_sel;
    logic [31:0] ret;
    logic        flt;
  } obs_t;

  obs_t        exp_q[$];
  logic [31:0] exp_ret;
  logic        exp_flt;
  int          checks   = 0;
  int          failures = 0;

  mc_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .ovf(ovf), .gtz(gtz),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
    .wb_sel(wb_sel), .retired(retired), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the queued expectation.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = '{mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
              alu_src_b, alu_op, reg_write, reg_dst, wb_sel, retired, fault};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL cycle_ctl op=%h t=%0t actual=%h expected=%h", opcode, $time, a, e);
        end
      end
    end
  end

  function automatic obs_t blank();
    obs_t e;
    e     = '0;
    e.ret = exp_ret;
    e.flt = exp_flt;
    return e;
  endfunction

  task automatic cyc(input obs_t e, input logic ack);
    mem_ack = ack;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int flat);
    obs_t e;
    for (int i = 0; i < flat; i++) begin
      e = blank(); e.mem_req = 1'b1; e.alu_src_b = 2'd1;
      if (i == flat - 1) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
      cyc(e, i == flat - 1);
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic z, input logic o, input logic g,
                           input int flat, input int mlat, input logic noise);
    obs_t e;
    logic tk;
    opcode = op; zero = z; ovf = o; gtz = g;
    fetch(flat);
    e = blank(); e.alu_src_b = 2'd3; cyc(e, noise);
    case (op)
      OP_RTYPE: begin
        e = blank(); e.alu_src_a = 1'b1; e.alu_op = 2'd2; cyc(e, noise);
        e = blank(); e.reg_write = 1'b1; e.reg_dst = 2'd1; cyc(e, noise);
      end
      OP_LW, OP_SW, OP_JMNOR: begin
        e = blank(); e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; cyc(e, noise);
        for (int i = 0; i < mlat; i++) begin
          e = blank(); e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = (op == OP_SW);
          cyc(e, i == mlat - 1);
        end
        if (op == OP_LW) begin
          e = blank(); e.reg_write = 1'b1; e.reg_dst = 2'd0; e.wb_sel = 2'd1; cyc(e, noise);
        end else if (op == OP_JMNOR) begin
          e = blank(); e.pc_write = 1'b1; e.pc_src = 2'd3; e.reg_write = 1'b1;
          e.reg_dst = 2'd3; e.wb_sel = 2'd2; cyc(e, noise);
        end
      end
      OP_BEQ, OP_BGTZAL, OP_BALV, OP_BRNV: begin
        tk = (op == OP_BEQ) ? z : (op == OP_BGTZAL) ? g : (op == OP_BALV) ? o : !o;
        e = blank(); e.alu_src_a = 1'b1; e.alu_op = 2'd1;
        if (tk) begin e.pc_write = 1'b1; e.pc_src = (op == OP_BRNV) ? 2'd2 : 2'd1; end
        cyc(e, noise);
        if (tk && (op == OP_BGTZAL || op == OP_BALV)) begin
          e = blank(); e.reg_write = 1'b1; e.wb_sel = 2'd2;
          e.reg_dst = (op == OP_BGTZAL) ? 2'd2 : 2'd3;
          cyc(e, noise);
        end
      end
      OP_JRSAL: begin
        e = blank(); e.pc_write = 1'b1; e.pc_src = 2'd2; e.reg_write = 1'b1;
        e.reg_dst = 2'd1; e.wb_sel = 2'd2; cyc(e, noise);
      end
      default: begin
        e = blank(); cyc(e, noise);
`ifdef MC_ILLEGAL_TRAP_EN
        exp_flt = 1'b1;
        for (int i = 0; i < 3; i++) begin e = blank(); cyc(e, 1'b1); end
        return;
`endif
      end
    endcase
    e = blank(); cyc(e, noise);
    exp_ret = exp_ret + 32'd1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    mem_ack = 1'b1;
    #1;
    chk("rst_drops_req", 32'(mem_req), 32'd0);
    chk("rst_drops_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_retired", retired, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_alu_src_b", 32'(alu_src_b), 32'd1);
    rst_n   = 1'b1;
    mem_ack = 1'b0;
    exp_ret = '0;
    exp_flt = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    obs_t e;
    rst_n = 1'b0; mem_ack = 1'b0; opcode = '0; zero = 1'b0; ovf = 1'b0; gtz = 1'b0;
    exp_ret = '0; exp_flt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    run_instr(OP_RTYPE, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);
    chk("rtype_retired", retired, 32'd1);
    run_instr(OP_RTYPE, 1'b0, 1'b0, 1'b0, 2, 0, 1'b1);
    run_instr(OP_BEQ, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0);
    run_instr(OP_BEQ, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);
    run_instr(OP_BGTZAL, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0);
    run_instr(OP_BGTZAL, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);
    run_instr(OP_BALV, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);
    run_instr(OP_BALV, 1'b0, 1'b1, 1'b0, 1, 0, 1'b0);
    run_instr(OP_BRNV, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);
    run_instr(OP_BRNV, 1'b0, 1'b1, 1'b0, 1, 0, 1'b0);
    run_instr(OP_LW, 1'b0, 1'b0, 1'b0, 1, 2, 1'b0);
    run_instr(OP_JMNOR, 1'b0, 1'b0, 1'b0, 1, 3, 1'b0);
    run_instr(OP_SW, 1'b0, 1'b0, 1'b0, 2, 4, 1'b1);
    run_instr(OP_JRSAL, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);
    // Ack on the 15th fetch cycle: just inside the timeout.
    run_instr(OP_RTYPE, 1'b0, 1'b0, 1'b0, 15, 0, 1'b0);
    chk("boundary_retired", retired, 32'd15);
    chk("boundary_nofault", 32'(fault), 32'd0);

    run_instr(6'h3F, 1'b0, 1'b0, 1'b0, 1, 0, 1'b1);
`ifdef MC_ILLEGAL_TRAP_EN
    chk("illegal_retired", retired, 32'd15);
    chk("illegal_fault", 32'(fault), 32'd1);
`else
    chk("illegal_retired", retired, 32'd16);
    chk("illegal_fault", 32'(fault), 32'd0);
`endif
    do_reset();

    // Reset in the middle of a store transfer.
    opcode = OP_SW;
    fetch(1);
    e = blank(); e.alu_src_b = 2'd3; cyc(e, 1'b0);
    e = blank(); e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; cyc(e, 1'b0);
    e = blank(); e.mem_req = 1'b1; e.mem_we = 1'b1; e.iord = 1'b1; cyc(e, 1'b0);
    chk("memwr_req_before_rst", 32'(mem_req), 32'd1);
    do_reset();

    // Fetch never acked: fault after 15 waiting cycles, HALT ignores acks.
    opcode = OP_RTYPE;
    for (int i = 0; i < 15; i++) begin
      e = blank(); e.mem_req = 1'b1; e.alu_src_b = 2'd1; cyc(e, 1'b0);
    end
    exp_flt = 1'b1;
    for (int i = 0; i < 4; i++) begin e = blank(); cyc(e, 1'b1); end
    chk("timeout_fault", 32'(fault), 32'd1);
    chk("timeout_retired", retired, 32'd0);
    do_reset();

    run_instr(OP_RTYPE, 1'b0, 1'b0, 1'b0, 3, 0, 1'b0);
    chk("post_reset_retired", retired, 32'd1);

    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
